minmax_stream: RTL and testbench

MINMAX_STREAM -- requirements
Module: minmax_stream

---
 rtl/minmax_stream.sv | 134 +++++++++++++
 tb/tb_minmax_stream.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/minmax_stream.sv
// Streaming min/max finder: scans a frame of up to NI elements and reports the
// extreme value, its position and whether the frame was cut off by the NI limit.
//
// state | meaning
// IDLE  | no element held, waiting for the first element of a frame
// ACCUM | frame in progress, running extreme kept in run_val/run_idx
// DONE  | result held on out_*, waiting for the downstream handshake
module minmax_stream #(
  parameter int W    = 6,
  parameter int NI   = 7,
  parameter int IDXW = $clog2(NI)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [W-1:0]    in_data,
  input  logic            in_last,
  input  logic            us_sel,
  input  logic            min_max_sel,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [W-1:0]    out_result,
  output logic [IDXW-1:0] out_index,
  output logic            out_trunc
);

  localparam int CW = $clog2(NI + 1);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t          state;
  logic [CW-1:0]   count;
  logic [W-1:0]    run_val;
  logic [IDXW-1:0] run_idx;
  logic            sgn_q;
  logic            max_q;

  logic            accept;
  logic            take;
  logic            closing;
  logic [W-1:0]    nxt_val;
  logic [IDXW-1:0] nxt_idx;
  logic [CW-1:0]   nxt_cnt;

  // Strict compare only, so a tie never displaces the earlier element.
  function automatic logic wins(input logic [W-1:0] cand, input logic [W-1:0] best,
                                input logic sgn, input logic mx);
    logic lt;
    logic gt;
    if (sgn) begin
      lt = $signed(cand) < $signed(best);
      gt = $signed(cand) > $signed(best);
    end else begin
      lt = cand < best;
      gt = cand > best;
    end
    return mx ? gt : lt;
  endfunction

  assign in_ready = !rst && (state != DONE);
  assign accept   = in_valid && in_ready;

  always_comb begin
    take    = 1'b0;
    nxt_val = run_val;
    nxt_idx = run_idx;
    nxt_cnt = count + CW'(1);
    if (state == IDLE) begin
      take    = 1'b1;
      nxt_val = in_data;
      nxt_idx = '0;
      nxt_cnt = CW'(1);
    end else begin
      take = wins(in_data, run_val, sgn_q, max_q);
      if (take) begin
        nxt_val = in_data;
        nxt_idx = IDXW'(count);
      end
    end
    closing = in_last || (nxt_cnt == CW'(NI));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      count      <= '0;
      run_val    <= '0;
      run_idx    <= '0;
      sgn_q      <= 1'b0;
      max_q      <= 1'b0;
      out_valid  <= 1'b0;
      out_result <= '0;
      out_index  <= '0;
      out_trunc  <= 1'b0;
    end else begin
      case (state)
        IDLE, ACCUM: begin
          if (accept) begin
            if (state == IDLE) begin
              sgn_q <= us_sel;
              max_q <= min_max_sel;
            end
            run_val <= nxt_val;
            run_idx <= nxt_idx;
            count   <= nxt_cnt;
            if (closing) begin
              state      <= DONE;
              out_valid  <= 1'b1;
              out_result <= nxt_val;
              out_index  <= nxt_idx;
              out_trunc  <= !in_last;
            end else begin
              state <= ACCUM;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            count     <= '0;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          count     <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_minmax_stream.sv
// Directed bench for minmax_stream: hand-computed frames covering min/max,
// signedness, ties, back-pressure, NI truncation and mid-frame reset.
module tb_minmax_stream;
  localparam int W    = 6;
  localparam int NI   = 7;
  localparam int IDXW = 3;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [W-1:0]    in_data = '0;
  logic            in_last = 1'b0;
  logic            us_sel = 1'b0;
  logic            min_max_sel = 1'b0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [W-1:0]    out_result;
  logic [IDXW-1:0] out_index;
  logic            out_trunc;

  int n_cmp = 0;
  int n_bad = 0;

  minmax_stream #(.W(W), .NI(NI), .IDXW(IDXW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .us_sel(us_sel),
    .min_max_sel(min_max_sel), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_index(out_index), .out_trunc(out_trunc)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Presents one element and returns 1 time unit after the accepting edge.
  task automatic push(input logic [W-1:0] d, input logic l, input logic us, input logic mm);
    int n;
    @(negedge clk);
    in_valid = 1'b1; in_data = d; in_last = l; us_sel = us; min_max_sel = mm;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) check_val("push_ready_timeout", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic check_frame(input string tag, input logic [W-1:0] r,
                             input logic [IDXW-1:0] i, input logic t);
    check_val({tag, "_valid"}, 32'(out_valid), 32'd1);
    check_val({tag, "_result"}, 32'(out_result), 32'(r));
    check_val({tag, "_index"}, 32'(out_index), 32'(i));
    check_val({tag, "_trunc"}, 32'(out_trunc), 32'(t));
    check_val({tag, "_ready"}, 32'(in_ready), 32'd0);
  endtask

  task automatic take(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check_val({tag, "_released"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    // reset state
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_in_ready", 32'(in_ready), 32'd0);
    check_val("rst_out_valid", 32'(out_valid), 32'd0);
    check_val("rst_out_result", 32'(out_result), 32'd0);
    check_val("rst_out_index", 32'(out_index), 32'd0);
    check_val("rst_out_trunc", 32'(out_trunc), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_val("post_rst_in_ready", 32'(in_ready), 32'd1);

    // unsigned max with a tie at 17
    push(6'd3, 1'b0, 1'b0, 1'b1);
    push(6'd17, 1'b0, 1'b0, 1'b1);
    push(6'd9, 1'b0, 1'b0, 1'b1);
    check_val("umax_not_yet", 32'(out_valid), 32'd0);
    push(6'd17, 1'b1, 1'b0, 1'b1);
    check_frame("umax", 6'd17, 3'd1, 1'b0);
    take("umax");

    // signed min vs unsigned min on the same data
    push(6'h3F, 1'b0, 1'b1, 1'b0);
    push(6'h20, 1'b0, 1'b1, 1'b0);
    push(6'h05, 1'b1, 1'b1, 1'b0);
    check_frame("smin", 6'h20, 3'd1, 1'b0);
    take("smin");
    push(6'h3F, 1'b0, 1'b0, 1'b0);
    push(6'h20, 1'b0, 1'b0, 1'b0);
    push(6'h05, 1'b1, 1'b0, 1'b0);
    check_frame("umin", 6'h05, 3'd2, 1'b0);
    take("umin");

    // signed max across the sign boundary
    push(6'h20, 1'b0, 1'b1, 1'b1);
    push(6'h1F, 1'b1, 1'b1, 1'b1);
    check_frame("smax", 6'h1F, 3'd1, 1'b0);
    take("smax");

    // single element frame
    push(6'h2A, 1'b1, 1'b1, 1'b0);
    check_frame("single", 6'h2A, 3'd0, 1'b0);
    take("single");

    // mode inputs changed mid-frame must be ignored (frame is unsigned max)
    push(6'h05, 1'b0, 1'b0, 1'b1);
    push(6'h30, 1'b0, 1'b0, 1'b0);
    push(6'h02, 1'b1, 1'b1, 1'b0);
    check_frame("mode_latch", 6'h30, 3'd1, 1'b0);
    take("mode_latch");

    // all-equal min frame keeps the first element
    push(6'd4, 1'b0, 1'b0, 1'b0);
    push(6'd4, 1'b0, 1'b0, 1'b0);
    push(6'd4, 1'b1, 1'b0, 1'b0);
    check_frame("tie", 6'd4, 3'd0, 1'b0);
    take("tie");

    // back-pressure: result held, input blocked until handshake
    push(6'd10, 1'b0, 1'b0, 1'b0);
    push(6'd20, 1'b1, 1'b0, 1'b0);
    check_frame("hold", 6'd10, 3'd0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (k == 0) begin
        in_valid = 1'b1; in_data = 6'd7; in_last = 1'b1; us_sel = 1'b0; min_max_sel = 1'b0;
      end
      @(posedge clk);
      #1;
      check_frame("hold_stall", 6'd10, 3'd0, 1'b0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check_val("hold_release_valid", 32'(out_valid), 32'd0);
    check_val("hold_release_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0; in_last = 1'b0;
    check_frame("after_hold", 6'd7, 3'd0, 1'b0);
    take("after_hold");

    // NI-limit truncation, then a fresh frame at index 0
    for (int k = 0; k < NI - 1; k++) push(6'(k), 1'b0, 1'b0, 1'b1);
    check_val("trunc_not_yet", 32'(out_valid), 32'd0);
    push(6'd6, 1'b0, 1'b0, 1'b1);
    check_frame("trunc", 6'd6, 3'd6, 1'b1);
    take("trunc");
    push(6'd9, 1'b1, 1'b0, 1'b1);
    check_frame("after_trunc", 6'd9, 3'd0, 1'b0);
    take("after_trunc");

    // NI-th element carrying in_last is not a truncation
    for (int k = 0; k < NI - 1; k++) push(6'(12 - k), 1'b0, 1'b0, 1'b0);
    push(6'd30, 1'b1, 1'b0, 1'b0);
    check_frame("full_last", 6'd7, 3'd5, 1'b0);
    take("full_last");

    // reset mid-frame discards the partial frame
    push(6'd3, 1'b0, 1'b0, 1'b1);
    push(6'd8, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_val("midrst_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    check_val("midrst_out_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_val("midrst_no_pulse", 32'(out_valid), 32'd0);
    push(6'd5, 1'b1, 1'b0, 1'b0);
    check_frame("post_midrst", 6'd5, 3'd0, 1'b0);
    take("post_midrst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
